// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined right shifter.
//   shift_mode_e : fill policy for vacated high-order bits.
//   stage_count  : number of pipeline stages (and distance width) for width n.
// ---------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic {
        SHIFT_LOGICAL = 1'b0,
        SHIFT_ARITH   = 1'b1
    } shift_mode_e;

    function automatic int stage_count(int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/right_shift_stage.sv
// ---------------------------------------------------------------------------
// right_shift_stage
// One registered slot of the right-shift pipeline. The incoming operand is
// shifted right by 2^K when distance bit K is set, and the bits dropped off
// the bottom are ORed into the sticky flag before the result is registered.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   i_valid        upstream slot holds an operand
//   o_ready        this slot can take an operand this cycle
//   i_data/i_dist/i_mode/i_sticky   operand from upstream
//   o_valid        this slot holds an operand
//   i_next_ready   downstream slot can take an operand
//   o_data/o_dist/o_mode/o_sticky   registered operand for downstream
// ---------------------------------------------------------------------------
module right_shift_stage
    import shifter_pkg::*;
#(
    parameter int N       = 32,
    parameter int D_WIDTH = stage_count(N),
    parameter int K       = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N-1:0]       i_data,
    input  logic [D_WIDTH-1:0] i_dist,
    input  shift_mode_e        i_mode,
    input  logic               i_sticky,
    output logic               o_valid,
    input  logic               i_next_ready,
    output logic [N-1:0]       o_data,
    output logic [D_WIDTH-1:0] o_dist,
    output shift_mode_e        o_mode,
    output logic               o_sticky
);

    // 2^K is always below N because K <= $clog2(N)-1.
    localparam int S = 1 << K;

    logic               w_fill;
    logic [N-1:0]       w_shifted;
    logic [N-1:0]       w_data_next;
    logic               w_sticky_next;
    logic               w_ready;

    logic               r_valid;
    logic [N-1:0]       r_data;
    logic [D_WIDTH-1:0] r_dist;
    shift_mode_e        r_mode;
    logic               r_sticky;

    assign w_fill        = (i_mode == SHIFT_ARITH) & i_data[N-1];
    assign w_shifted     = {{S{w_fill}}, i_data[N-1:S]};
    assign w_data_next   = i_dist[K] ? w_shifted : i_data;
    assign w_sticky_next = i_sticky | (i_dist[K] & (|i_data[S-1:0]));

    // The slot can load when empty or when its occupant leaves this cycle.
    assign w_ready = !r_valid | i_next_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_dist   <= '0;
            r_mode   <= SHIFT_LOGICAL;
            r_sticky <= 1'b0;
        end else if (w_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data   <= w_data_next;
                r_dist   <= i_dist;
                r_mode   <= i_mode;
                r_sticky <= w_sticky_next;
            end
        end
    end

    assign o_ready  = w_ready;
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_dist   = r_dist;
    assign o_mode   = r_mode;
    assign o_sticky = r_sticky;

endmodule

// File: rtl/pipelined_right_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_right_shifter
// z = x >> d (logical or arithmetic) with a sticky bit that ORs every bit
// shifted out past bit 0. One stage per distance bit; valid/ready on both
// sides with a combinational ready chain, one result per cycle.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   x, d, arith           operand, shift distance, sign-fill select
//   out_valid / out_ready output handshake
//   z, sticky             registered result from the last stage
// ---------------------------------------------------------------------------
module pipelined_right_shifter
    import shifter_pkg::*;
#(
    parameter int N       = 32,
    parameter int D_WIDTH = stage_count(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       x,
    input  logic [D_WIDTH-1:0] d,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       z,
    output logic               sticky
);

    generate
        if (N < 2) begin : g_bad_width
            $error("pipelined_right_shifter: N must be at least 2");
        end
    endgenerate

    // Index k is the boundary feeding stage k; index D_WIDTH is the output.
    logic               w_valid  [D_WIDTH+1];
    logic               w_ready  [D_WIDTH+1];
    logic [N-1:0]       w_data   [D_WIDTH+1];
    logic [D_WIDTH-1:0] w_dist   [D_WIDTH+1];
    shift_mode_e        w_mode   [D_WIDTH+1];
    logic               w_sticky [D_WIDTH+1];

    assign w_valid[0]       = in_valid;
    assign w_data[0]        = x;
    assign w_dist[0]        = d;
    assign w_mode[0]        = shift_mode_e'(arith);
    assign w_sticky[0]      = 1'b0;
    assign w_ready[D_WIDTH] = out_ready;

    generate
        for (genvar gi = 0; gi < D_WIDTH; gi++) begin : g_stage
            right_shift_stage #(
                .N       (N),
                .D_WIDTH (D_WIDTH),
                .K       (gi)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_valid      (w_valid[gi]),
                .o_ready      (w_ready[gi]),
                .i_data       (w_data[gi]),
                .i_dist       (w_dist[gi]),
                .i_mode       (w_mode[gi]),
                .i_sticky     (w_sticky[gi]),
                .o_valid      (w_valid[gi+1]),
                .i_next_ready (w_ready[gi+1]),
                .o_data       (w_data[gi+1]),
                .o_dist       (w_dist[gi+1]),
                .o_mode       (w_mode[gi+1]),
                .o_sticky     (w_sticky[gi+1])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[D_WIDTH];
    assign z         = w_data[D_WIDTH];
    assign sticky    = w_sticky[D_WIDTH];

endmodule

// File: tb/tb_pipelined_right_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_right_shifter
// Self-checking bench for the 32-bit pipelined right shifter. Expected
// results come from an arithmetic reference (>> / >>> and a low-bit mask)
// or from fixed constants, queued in acceptance order.
// ---------------------------------------------------------------------------
module tb_pipelined_right_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [4:0]  d;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        sticky;

    pipelined_right_shifter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .d         (d),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] z;
        logic        s;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cyc        = 0;
    int          n_out      = 0;
    bit          check_lat  = 1'b0;
    bit          force_exp  = 1'b0;
    logic [31:0] force_z    = '0;
    logic        force_s    = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_z     = '0;
    logic        prev_s     = 1'b0;
    bit          saw_full   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, want);
        end
    endtask

    // Reference: plain shift operators plus a mask of the low d bits.
    function automatic logic [32:0] ref_shift(input logic [31:0] xv, input int dv, input bit av);
        logic [31:0] zz;
        logic [63:0] mask;
        if (av) zz = 32'($signed(xv) >>> dv);
        else    zz = xv >> dv;
        mask = (64'd1 << dv) - 64'd1;
        return {|({32'd0, xv} & mask), zz};
    endfunction

    // One clock cycle: drive at negedge, evaluate handshakes, advance.
    task automatic step(input bit iv, input logic [31:0] ix, input logic [4:0] id,
                        input bit ia, input bit ordy, output bit accepted);
        exp_t        e;
        logic [32:0] r;
        in_valid  = iv;
        x         = ix;
        d         = id;
        arith     = ia;
        out_ready = ordy;
        #1;
        if (prev_stall) begin
            check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
            check_eq("stall_z", {32'd0, z}, {32'd0, prev_z});
            check_eq("stall_sticky", {63'd0, sticky}, {63'd0, prev_s});
        end
        if (!in_ready) saw_full = 1'b1;
        accepted = iv && in_ready;
        if (accepted) begin
            if (force_exp) begin
                e.z = force_z;
                e.s = force_s;
            end else begin
                r   = ref_shift(ix, int'(id), ia);
                e.z = r[31:0];
                e.s = r[32];
            end
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("z", {32'd0, z}, {32'd0, e.z});
                check_eq("sticky", {63'd0, sticky}, {63'd0, e.s});
                if (check_lat) check_eq("latency", 64'(cyc - e.acc), 64'd5);
                $display("cycle %0d: out z=%08h sticky=%0b (accepted cycle %0d)", cyc, z, sticky, e.acc);
                n_out++;
            end
        end
        prev_stall = out_valid && !ordy;
        prev_z     = z;
        prev_s     = sticky;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        bit acc;
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, acc);
            n++;
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic directed(input logic [31:0] ix, input logic [4:0] id, input bit ia,
                            input logic [31:0] ez, input logic es);
        bit acc;
        force_exp = 1'b1;
        force_z   = ez;
        force_s   = es;
        step(1'b1, ix, id, ia, 1'b1, acc);
        force_exp = 1'b0;
        check_eq("directed_accept", {63'd0, acc}, 64'd1);
        drain(20);
    endtask

    initial begin
        bit          acc;
        int          idx;
        int          c;
        int          sent;
        int          out_before;
        bit          pend;
        logic [31:0] px;
        logic [4:0]  pd;
        bit          pa;

        rst = 1'b1; in_valid = 1'b0; x = '0; d = '0; arith = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_z", {32'd0, z}, 64'd0);
        check_eq("rst_sticky", {63'd0, sticky}, 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Directed boundary and sticky cases.
        check_lat = 1'b1;
        directed(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
        check_lat = 1'b0;
        directed(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b0);
        directed(32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 1'b0);
        directed(32'h0000_00FF, 5'd4,  1'b0, 32'h0000_000F, 1'b1);
        directed(32'h0000_00F0, 5'd4,  1'b0, 32'h0000_000F, 1'b0);
        directed(32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0);
        directed(32'h8765_4321, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back operands with a downstream stall in cycles 6..9.
        saw_full   = 1'b0;
        out_before = n_out;
        idx = 0;
        c   = 1;
        while ((idx < 8 || exp_q.size() != 0) && c < 60) begin
            step(idx < 8, $urandom, 5'(idx), 1'($urandom_range(0, 1)),
                 !(c >= 6 && c <= 9), acc);
            if (acc) idx++;
            c++;
        end
        check_eq("b2b_in_ready_fell", {63'd0, saw_full}, 64'd1);
        check_eq("b2b_results", 64'(n_out - out_before), 64'd8);
        check_eq("b2b_leftover", 64'(exp_q.size()), 64'd0);

        // Randomised traffic against the reference.
        out_before = n_out;
        sent = 0;
        pend = 1'b0;
        c    = 0;
        while ((sent < 10000 || exp_q.size() != 0) && c < 60000) begin
            if (!pend && sent < 10000 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                px   = $urandom;
                pd   = 5'($urandom_range(0, 31));
                pa   = 1'($urandom_range(0, 1));
            end
            step(pend, px, pd, pa, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            c++;
        end
        check_eq("rand_results", 64'(n_out - out_before), 64'd10000);

        // Reset with operands in flight.
        exp_q.delete();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, acc);
        check_eq("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("async_z", {32'd0, z}, 64'd0);
        check_eq("async_sticky", {63'd0, sticky}, 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_before = n_out;
        for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, acc);
        check_eq("no_stale", 64'(n_out - out_before), 64'd0);
        directed(32'hF000_000F, 5'd8, 1'b1, 32'hFFF0_0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
